hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 25 ++
 rtl/hazard_scoreboard_md.sv | 34 +++
 rtl/hazard_scoreboard.sv | 91 +++++++++
 tb/tb_hazard_scoreboard.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the hazard scoreboard.
//   REG_ZERO           : hard-wired zero register index
//   NUM_REGS           : architectural register count
//   MD_CNT_W           : width of the multicycle countdown
//   MD_LATENCY_DEFAULT : default mult/div latency in cycles
package hazard_scoreboard_pkg;

  localparam logic [4:0]  REG_ZERO           = 5'd0;
  localparam int unsigned NUM_REGS           = 32;
  localparam int unsigned MD_CNT_W           = 4;
  localparam int unsigned MD_LATENCY_DEFAULT = 4;

  typedef logic [4:0] reg_idx_t;

  // Number of set bits in a register mask (0..32 fits in 6 bits).
  function automatic logic [5:0] popcount_regs(input logic [NUM_REGS-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_md.sv
// Multicycle (mult/div) countdown.
//   clk, reset : clock and asynchronous active-high reset
//   load       : a multicycle op issues this cycle; reload the latency
//   busy       : counter is non-zero
//   done       : counter is at its last cycle (== 1)
module md_countdown
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy,
  output logic done
);

  logic [MD_CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      // Load takes priority so a new op can issue in the done cycle.
      count_q <= MD_CNT_W'(MD_LATENCY);
    end else if (count_q != '0) begin
      count_q <= count_q - MD_CNT_W'(1);
    end
  end

  assign busy = (count_q != '0);
  assign done = (count_q == MD_CNT_W'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard and ID-stage hazard detection.
// Tracks destinations of in-flight loads and mult/div ops (the results the
// forwarding network cannot supply) and stalls ID on RAW, WAW and
// mult/div structural hazards.
//   ID_*          : decoded ID-stage instruction fields
//   WB_reg_write/WB_reg_rd : writeback this cycle
//   flush         : squash the ID instruction
//   stall, issue  : combinational pipeline control
//   md_busy/md_done : mult/div unit status
//   pending_count : registered number of pending registers
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ID_valid,
  input  logic [4:0] ID_reg_rs,
  input  logic [4:0] ID_reg_rt,
  input  logic       ID_uses_rs,
  input  logic       ID_uses_rt,
  input  logic       ID_reg_write,
  input  logic [4:0] ID_reg_rd,
  input  logic       ID_mem_read,
  input  logic       ID_multi,
  input  logic       WB_reg_write,
  input  logic [4:0] WB_reg_rd,
  input  logic       flush,
  output logic       stall,
  output logic       issue,
  output logic       md_busy,
  output logic       md_done,
  output logic [5:0] pending_count
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] wb_vec, set_vec, eff_pending;
  logic                raw, waw, structural, set_pend;

  // Writeback lands in the first half-cycle, so a register being written
  // back this cycle is already readable by ID.
  always_comb begin
    wb_vec = '0;
    if (WB_reg_write && (WB_reg_rd != REG_ZERO)) wb_vec[WB_reg_rd] = 1'b1;
  end

  assign eff_pending = pending_q & ~wb_vec;

  assign raw = ID_valid && ((ID_uses_rs && eff_pending[ID_reg_rs]) ||
                            (ID_uses_rt && eff_pending[ID_reg_rt]));
  assign waw = ID_valid && ID_reg_write && (ID_reg_rd != REG_ZERO) &&
               eff_pending[ID_reg_rd];
  assign structural = ID_valid && ID_multi && md_busy && !md_done;

  assign stall = (raw || waw || structural) && !flush;
  assign issue = ID_valid && !stall && !flush;

  // Only loads and mult/div are tracked; ALU results are forwarded.
  assign set_pend = issue && ID_reg_write && (ID_mem_read || ID_multi) &&
                    (ID_reg_rd != REG_ZERO);

  always_comb begin
    set_vec = '0;
    if (set_pend) set_vec[ID_reg_rd] = 1'b1;
    // Clear first, then set, so a same-edge set wins.
    pending_d    = (pending_q & ~wb_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q     <= '0;
      pending_count <= '0;
    end else begin
      pending_q     <= pending_d;
      pending_count <= popcount_regs(pending_d);
    end
  end

  md_countdown #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_countdown (
    .clk  (clk),
    .reset(reset),
    .load (issue && ID_multi),
    .busy (md_busy),
    .done (md_done)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int unsigned LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ID_valid, ID_uses_rs, ID_uses_rt, ID_reg_write, ID_mem_read, ID_multi;
  logic [4:0] ID_reg_rs, ID_reg_rt, ID_reg_rd, WB_reg_rd;
  logic       WB_reg_write, flush;
  logic       stall, issue, md_busy, md_done;
  logic [5:0] pending_count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .MD_LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ID_valid     (ID_valid),
    .ID_reg_rs    (ID_reg_rs),
    .ID_reg_rt    (ID_reg_rt),
    .ID_uses_rs   (ID_uses_rs),
    .ID_uses_rt   (ID_uses_rt),
    .ID_reg_write (ID_reg_write),
    .ID_reg_rd    (ID_reg_rd),
    .ID_mem_read  (ID_mem_read),
    .ID_multi     (ID_multi),
    .WB_reg_write (WB_reg_write),
    .WB_reg_rd    (WB_reg_rd),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .pending_count(pending_count)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic       urs;
    logic [4:0] rt;
    logic       urt;
    logic       rw;
    logic [4:0] rd;
    logic       mr;
    logic       multi;
    logic       wbw;
    logic [4:0] wbrd;
    logic       flush;
    logic       e_stall;
    logic       e_issue;
    logic       e_busy;
    logic       e_done;
    int         e_cnt;
  } vec_t;

  function automatic vec_t mk(logic valid, logic [4:0] rs, logic urs, logic [4:0] rt,
                              logic urt, logic rw, logic [4:0] rd, logic mr, logic multi,
                              logic wbw, logic [4:0] wbrd, logic fl, logic es, logic ei,
                              logic eb, logic ed, int ec);
    vec_t v;
    v.valid = valid; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt; v.rw = rw;
    v.rd = rd; v.mr = mr; v.multi = multi; v.wbw = wbw; v.wbrd = wbrd; v.flush = fl;
    v.e_stall = es; v.e_issue = ei; v.e_busy = eb; v.e_done = ed; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic apply(input vec_t v);
    ID_valid = v.valid; ID_reg_rs = v.rs; ID_uses_rs = v.urs; ID_reg_rt = v.rt;
    ID_uses_rt = v.urt; ID_reg_write = v.rw; ID_reg_rd = v.rd; ID_mem_read = v.mr;
    ID_multi = v.multi; WB_reg_write = v.wbw; WB_reg_rd = v.wbrd; flush = v.flush;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, ".stall"}, int'(stall), int'(v.e_stall));
    chk({tag, ".issue"}, int'(issue), int'(v.e_issue));
    chk({tag, ".md_busy"}, int'(md_busy), int'(v.e_busy));
    chk({tag, ".md_done"}, int'(md_done), int'(v.e_done));
    chk({tag, ".pending_count"}, int'(pending_count), v.e_cnt);
  endtask

  // Inputs change at negedge, outputs sampled 1ns later, then one clock edge.
  task automatic step(input string tag, input vec_t v);
    apply(v);
    #1;
    check_outs(tag, v);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: set of pending registers and remaining mult/div cycles.
  bit m_pend[32];
  int m_md;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_md = 0;
  endtask

  function automatic bit m_eff(int r);
    return m_pend[r] && !(WB_reg_write && int'(WB_reg_rd) == r);
  endfunction

  task automatic rand_step(input int idx);
    bit e_raw, e_waw, e_struct, e_stall, e_issue, e_busy, e_done;
    int e_cnt;
    vec_t v;
    v = mk($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
           5'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 4) != 0,
           5'($urandom_range(0, 7)), $urandom_range(0, 9) < 3, $urandom_range(0, 19) < 3,
           $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
           0, 0, 0, 0, 0);
    apply(v);
    e_busy   = (m_md != 0);
    e_done   = (m_md == 1);
    e_raw    = v.valid && ((v.urs && m_eff(int'(v.rs))) || (v.urt && m_eff(int'(v.rt))));
    e_waw    = v.valid && v.rw && v.rd != 0 && m_eff(int'(v.rd));
    e_struct = v.valid && v.multi && e_busy && !e_done;
    e_stall  = (e_raw || e_waw || e_struct) && !v.flush;
    e_issue  = v.valid && !e_stall && !v.flush;
    e_cnt    = 0;
    for (int i = 0; i < 32; i++) e_cnt += int'(m_pend[i]);
    #1;
    chk($sformatf("rand%0d.stall", idx), int'(stall), int'(e_stall));
    chk($sformatf("rand%0d.issue", idx), int'(issue), int'(e_issue));
    chk($sformatf("rand%0d.md_busy", idx), int'(md_busy), int'(e_busy));
    chk($sformatf("rand%0d.md_done", idx), int'(md_done), int'(e_done));
    chk($sformatf("rand%0d.pending_count", idx), int'(pending_count), e_cnt);
    @(posedge clk);
    if (e_issue && v.multi) m_md = int'(LAT);
    else if (m_md > 0) m_md--;
    if (v.wbw && v.wbrd != 0) m_pend[v.wbrd] = 1'b0;
    if (e_issue && v.rw && (v.mr || v.multi) && v.rd != 0) m_pend[v.rd] = 1'b1;
    @(negedge clk);
  endtask

  vec_t tbl[17];
  vec_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // valid rs urs rt urt rw rd mr mu wbw wbrd fl | stall issue busy done cnt
    tbl[0]  = idle;
    tbl[1]  = mk(1, 17, 1, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);  // lw $t1
    tbl[2]  = mk(1, 9, 1, 0, 0, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);   // use $t1: stall
    tbl[3]  = mk(0, 9, 1, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // not valid
    tbl[4]  = mk(1, 0, 0, 9, 1, 1, 8, 0, 0, 1, 9, 0, 0, 1, 0, 0, 1);   // WB bypass
    tbl[5]  = idle;
    tbl[6]  = mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);   // lw $0
    tbl[7]  = mk(1, 0, 1, 0, 1, 1, 12, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);  // read $0
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);  // lw $t2
    tbl[9]  = mk(1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1);  // waw stall
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 10, 1, 0, 1, 10, 0, 0, 1, 0, 0, 1); // waw + WB: set wins
    tbl[11] = mk(1, 10, 1, 0, 0, 1, 11, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1); // flushed load-use
    tbl[12] = idle; tbl[12].e_cnt = 1;
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 1);  // WB $t2
    tbl[14] = idle;
    tbl[15] = mk(1, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);  // ALU -> $t3
    tbl[16] = mk(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);  // read $t3: forwarded

    apply(idle);
    reset = 1'b1;
    #3;
    check_outs("reset", idle);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) step($sformatf("tbl%0d", i), tbl[i]);

    // Back-to-back MULs: second waits through cycles 1..3, issues in the done cycle.
    step("mul0", mk(1, 0, 0, 0, 0, 1, 16, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      step($sformatf("mul%0d", k),
           mk(1, 8, 1, 0, 0, 1, 17, 0, 1, 0, 0, 0, k < 4, k == 4, 1, k == 4, 1));
    end
    step("lw5", mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2));

    // Asynchronous reset mid-countdown with three pending registers.
    apply(idle);
    #1;
    chk("prerst.pending_count", int'(pending_count), 3);
    chk("prerst.md_busy", int'(md_busy), 1);
    #1;
    reset = 1'b1;
    #1;
    check_outs("midrst", idle);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step($sformatf("postrst%0d", i), idle);

    model_reset();
    for (int i = 0; i < 1500; i++) rand_step(i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
